dmem_lsu: RTL
=============

Name: dmem_lsu

Overview:
- Load/store initiator that drives the word-wide data memory port (WE, A, WD, RD) on behalf of the core datapath.
- Accepts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) over a valid/ready handshake.
- Performs read-modify-write for sub-word stores and extracts/extends sub-word loads.
- Returns one response per request. Sits between the execute stage and the data memory instance.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits (fixed 32; sub-word lanes assume 4 bytes).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request; equals (state==IDLE).
- req_we  input  1  1=store, 0=load.
- req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  AW  byte address.
- req_wdata  input  DW  store data, LSB-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_rdata  output  DW  load result, extended; 0 for stores.
- rsp_err  output  1  misaligned address or illegal funct3; no memory access performed.
- WE  output  1  data memory write enable; memory writes WD at posedge when WE=1.
- A  output  AW  data memory address, always {addr[AW-1:2],2'b00}.
- WD  output  DW  data memory write data.
- RD  input  DW  data memory read data; combinational from A.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; WE=0, A=0, WD=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready=1 while in IDLE, including during reset.
- Accept: req_valid && req_ready at posedge. Latch we, funct3, addr, wdata. Next state:
  - ERR if misaligned (H with addr[0]=1; W with addr[1:0]!=0) or funct3 in {011,110,111}.
  - WRITE if SW.
  - READ otherwise.
- READ (1 cycle): A driven from the latched address, WE=0. Capture RD into a word register at the posedge ending the cycle. Next state: MERGE for SB/SH, RESP for loads.
- MERGE (1 cycle): WE=1, A held, WD=captured word with the selected lane replaced.
  - SB: byte lane addr[1:0] = wdata[7:0].
  - SH: half lane addr[1] = wdata[15:0].
  - Next state: RESP.
- WRITE (1 cycle, SW only): WE=1, WD=wdata. Next state: RESP.
- ERR: go to RESP with rsp_err=1. WE never asserted.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are registered and stable while rsp_valid=1 and rsp_ready=0. On rsp_ready=1 at posedge, return to IDLE and clear rsp_valid.
- Load extraction from the captured word:
  - LB/LBU: byte at addr[1:0], sign/zero-extended to 32 bits.
  - LH/LHU: half at addr[1], sign/zero-extended.
  - LW: full word.
- WE is asserted only in MERGE/WRITE, at most 1 cycle per store. WD=0 and WE=0 in all other states. A holds its last value outside active states.
- Latency, accept posedge N to rsp_valid high:
  - Load: cycle N+2.
  - SW: cycle N+2.
  - SB/SH: cycle N+3.
  - Error: cycle N+2.
- Back-to-back: a new request can be accepted at most one cycle after rsp handshake, since req_ready=1 only in IDLE. No overlap; one outstanding request.
- req_valid while not ready: ignored. Requester holds it.
- Reset mid-operation: WE drops immediately and combinationally-asynchronously (state cleared). An in-progress RMW performs no write. A pending response is discarded.
- Address bits [1:0] never appear on A.

Test Plan:
- Preload mem[0x10]=0x12345678. LW addr 0x10 -> A=0x10, WE never 1, rsp_rdata=0x12345678 at N+2, rsp_err=0.
- LB addr 0x13, then LBU addr 0x13, mem[0x10]=0x80FF00AA -> rsp_rdata=0xFFFFFF80 then 0x00000080. LH 0x12 -> 0xFFFF80FF. LHU 0x10 -> 0x000000AA.
- SB addr 0x11 wdata=0xDEADBEEF over 0x12345678 -> WE=1 for exactly one cycle (N+2) with WD=0x1234EF78. A subsequent LW 0x10 returns 0x1234EF78. SH 0x12 wdata 0xCAFE -> mem 0xCAFEEF78.
- SW addr 0x14 wdata=0x87654321 -> WE=1 at N+1 only, A=0x14, WD=0x87654321, rsp_valid at N+2, rsp_rdata=0.
- Misaligned LW 0x12 and SH 0x15 -> rsp_err=1 at N+2, WE stays 0, memory unchanged. funct3=011 -> rsp_err=1.
- Hold rsp_ready=0 for 5 cycles after a load -> rsp_valid/rsp_rdata stable, req_ready=0. Assert rst_n=0 during MERGE of an SB -> WE falls immediately, target word unchanged, all outputs at reset values, req_ready=1.

Source files
------------

// File: rtl/dmem_lsu_if.sv
// Bundles the load/store request/response handshake and the word-wide data
// memory port that dmem_lsu sits between.
interface dmem_lsu_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [2:0]    req_funct3;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          WE;
   logic [AW-1:0] A;
   logic [DW-1:0] WD;
   logic [DW-1:0] RD;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, RD,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, WE, A, WD
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, RD,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, WE, A, WD
   );
endinterface

// File: rtl/dmem_lsu.sv
// RV32I load/store unit: one outstanding request, read-modify-write for
// sub-word stores, sign/zero extension for sub-word loads.
module dmem_lsu #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   dmem_lsu_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, ERR, RESP} state_t;

   state_t        state, state_nxt;
   logic          we_q;
   logic [2:0]    f3_q;
   logic [1:0]    off_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] word_q;
   logic [AW-1:0] a_q;
   logic [DW-1:0] rdata_q;
   logic          err_q;
   logic          accept;
   logic          bad;

   function automatic logic req_illegal(input logic [2:0] f3, input logic [1:0] off);
      logic r;
      case (f3)
         3'b000, 3'b100: r = 1'b0;
         3'b001, 3'b101: r = off[0];
         3'b010:         r = (off != 2'b00);
         default:        r = 1'b1;
      endcase
      return r;
   endfunction

   function automatic logic [DW-1:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                  input logic [DW-1:0] w);
      logic signed [7:0]    b;
      logic signed [15:0]   h;
      logic signed [DW-1:0] r;
      b = w[{off, 3'b000} +: 8];
      h = w[{off[1], 4'b0000} +: 16];
      case (f3[1:0])
         2'b00:   r = f3[2] ? $signed({{(DW-8){1'b0}}, b}) : b;
         2'b01:   r = f3[2] ? $signed({{(DW-16){1'b0}}, h}) : h;
         default: r = w;
      endcase
      return r;
   endfunction

   function automatic logic [DW-1:0] store_merge(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [DW-1:0] w, input logic [DW-1:0] d);
      logic [DW-1:0] r;
      r = w;
      if (f3[1:0] == 2'b00) r[{off, 3'b000} +: 8]    = d[7:0];
      else                  r[{off[1], 4'b0000} +: 16] = d[15:0];
      return r;
   endfunction

   assign accept = bus.req_valid && (state == IDLE);
   assign bad    = req_illegal(bus.req_funct3, bus.req_addr[1:0]);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (bus.req_valid) begin
                   if (bad)                                       state_nxt = ERR;
                   else if (bus.req_we && bus.req_funct3 == 3'b010) state_nxt = WRITE;
                   else                                           state_nxt = READ;
                end
         READ:  state_nxt = we_q ? MERGE : RESP;
         MERGE, WRITE, ERR: state_nxt = RESP;
         RESP:  if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // WE/WD decode straight from state so an async reset kills a write at once
   always_comb begin
      bus.WE = 1'b0;
      bus.WD = '0;
      case (state)
         MERGE: begin
            bus.WE = 1'b1;
            bus.WD = store_merge(f3_q, off_q, word_q, wdata_q);
         end
         WRITE: begin
            bus.WE = 1'b1;
            bus.WD = wdata_q;
         end
         default: ;
      endcase
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.A         = a_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_q     <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         // A only moves for requests that really touch memory
         if (accept && !bad) a_q <= {bus.req_addr[AW-1:2], 2'b00};
         if (state == READ && !we_q) rdata_q <= load_extract(f3_q, off_q, bus.RD);
         if (state == ERR) err_q <= 1'b1;
         if (state == RESP && bus.rsp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= bus.req_we;
         f3_q    <= bus.req_funct3;
         off_q   <= bus.req_addr[1:0];
         wdata_q <= bus.req_wdata;
      end
      if (state == READ) word_q <= bus.RD;
   end

endmodule
